// File: rtl/aes_round_stage.sv
// rtl/aes_round_stage.sv - elastic AES round stage (encrypt/decrypt per transaction) with DEPTH-entry output FIFO
//
// Purpose: computes one AES round (forward or inverse, selected per
// transaction) on the pushed state and queues {result, mode, tag} in a
// small FIFO. in_ready depends only on registered occupancy, so there is
// no combinational path from out_ready to in_ready.
//
// Parameters:
//   ROUND_NUM  round index 1..`NUM_ROUNDS; the last round omits (Inv)MixColumns
//   DEPTH      FIFO entries (>=1, any value, not only powers of two)
//   TAG_WIDTH  sideband tag width
//
// Ports:
//   clock, reset (async, active-low), flush (sync, clears the FIFO)
//   in_valid/in_ready, in_state, in_key, in_decrypt, in_tag   : input side
//   out_valid/out_ready, out_state, out_decrypt, out_tag      : FIFO head
//   count                                                     : occupancy

`ifndef NUM_ROUNDS
`define NUM_ROUNDS 10
`endif

module aes_round_stage #(
    parameter int ROUND_NUM = 1,
    parameter int DEPTH     = 2,
    parameter int TAG_WIDTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [127:0]               in_state,
    input  logic [127:0]               in_key,
    input  logic                       in_decrypt,
    input  logic [TAG_WIDTH-1:0]       in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [127:0]               out_state,
    output logic                       out_decrypt,
    output logic [TAG_WIDTH-1:0]       out_tag,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic             IS_FINAL = (ROUND_NUM == `NUM_ROUNDS);

    // ---------------------------------------------------------------
    // GF(2^8) arithmetic, modulus x^8 + x^4 + x^3 + x + 1
    // ---------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse (and maps 0 to 0, as the S-box needs)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // S-box as inverse followed by the affine map, instead of a lookup table
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] y;
        y = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

    // ---------------------------------------------------------------
    // Round functions. Byte k of the state is bits [127-8k -: 8];
    // bytes are column-major, so row r / column c is byte 4c+r.
    // ---------------------------------------------------------------
    function automatic logic [127:0] enc_round(input logic [127:0] st, input logic [127:0] key);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        res = '0;
        for (int k = 0; k < 16; k++) s[k] = sbox(st[127-8*k -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c+r] = s[4*((c+r)%4)+r];
        if (!IS_FINAL) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
                t[4*c+3] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
            end
        end
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = t[k];
        return res ^ key;
    endfunction

    // Exact inverse of enc_round with the same key: AddRoundKey first,
    // then InvMixColumns, InvShiftRows, InvSubBytes.
    function automatic logic [127:0] dec_round(input logic [127:0] st, input logic [127:0] key);
        logic [7:0]   t [16];
        logic [7:0]   u [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] x;
        logic [127:0] res;
        res = '0;
        x   = st ^ key;
        for (int k = 0; k < 16; k++) t[k] = x[127-8*k -: 8];
        if (!IS_FINAL) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
                t[4*c+1] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
                t[4*c+2] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
                t[4*c+3] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
            end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                u[4*c+r] = t[4*((c-r+4)%4)+r];
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = inv_sbox(u[k]);
        return res;
    endfunction

    // ---------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------
    logic [127:0] w_enc;
    logic [127:0] w_dec;
    logic [127:0] w_result;

    always_comb begin
        w_enc    = enc_round(in_state, in_key);
        w_dec    = dec_round(in_state, in_key);
        w_result = in_decrypt ? w_dec : w_enc;
    end

    // ---------------------------------------------------------------
    // Output FIFO
    // ---------------------------------------------------------------
    logic [127:0]         r_mem_state [DEPTH];
    logic                 r_mem_dec   [DEPTH];
    logic [TAG_WIDTH-1:0] r_mem_tag   [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 w_push;
    logic                 w_pop;

    assign in_ready  = (r_count != FULL_CNT);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign out_state   = r_mem_state[r_rd_ptr];
    assign out_decrypt = r_mem_dec[r_rd_ptr];
    assign out_tag     = r_mem_tag[r_rd_ptr];
    assign count       = r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_state[i] <= '0;
                r_mem_dec[i]   <= 1'b0;
                r_mem_tag[i]   <= '0;
            end
        end else if (flush) begin
            // Flush wins over a same-cycle push/pop; storage is left as is
            // because out_* are don't-care while empty.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem_state[r_wr_ptr] <= w_result;
                r_mem_dec[r_wr_ptr]   <= in_decrypt;
                r_mem_tag[r_wr_ptr]   <= in_tag;
                r_wr_ptr              <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: doc/aes_round_stage.md
# aes_round_stage

Elastic, parametrised AES round pipeline stage: one encrypt or decrypt round per transaction, selected per transaction, with the result held in a DEPTH-entry output FIFO under valid/ready flow control.
- It is the successor to the fixed single-register buffered round.
- It lets round stages be chained with back-pressure and with mixed encrypt/decrypt traffic.
- A sideband tag travels with each state so that downstream logic can match results to requests.

## Interface
Parameters:
- ROUND_NUM, default 1: round index, 1..`NUM_ROUNDS`. When ROUND_NUM == `NUM_ROUNDS`, the final-round variant is used (no MixColumns / InvMixColumns).
- DEPTH, default 2: output FIFO entries, ≥1. DEPTH ≥ 2 is required for one transaction per cycle.
- TAG_WIDTH, default 4: width of the sideband tag, ≥1.

Ports:
- clock  in  1  single clock, all state on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- flush  in  1  synchronous; discards all FIFO contents.
- in_valid  in  1  input transaction present.
- in_ready  out  1  stage can accept an input this cycle.
- in_state  in  state_t (128)  round input state.
- in_key  in  roundKey_t (128)  round key for this transaction.
- in_decrypt  in  1  0 = Round, 1 = RoundInverse.
- in_tag  in  TAG_WIDTH  sideband tag, carried unchanged.
- out_valid  out  1  head entry present.
- out_ready  in  1  consumer accepts the head entry.
- out_state  out  state_t (128)  round result at the FIFO head.
- out_decrypt  out  1  mode bit of the head entry.
- out_tag  out  TAG_WIDTH  tag of the head entry.
- count  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- **Datapath:** Round #(ROUND_NUM) and RoundInverse #(ROUND_NUM) both compute combinationally from in_state and in_key. in_decrypt selects the result. Only the selected result and the mode bit are stored.
- **Push:** occurs when in_valid && in_ready. The FIFO writes {result, in_decrypt, in_tag} at the write pointer.
- **Pop:** occurs when out_valid && out_ready. The read pointer advances.
- **Ready and valid:**
  - in_ready = (count != DEPTH). It depends on registered state only, with no combinational path from out_ready.
  - out_valid = (count != 0).
  - out_* are driven from the entry at the read pointer. Their value is don't-care when out_valid = 0, but they must not be X after reset.
- **Pointers:** wrap from DEPTH-1 to 0. DEPTH need not be a power of two.
- **Occupancy update:**
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Push only: count +1.
  - Pop only: count -1.
- **Full (count == DEPTH):** in_ready = 0, so no push occurs even if a pop happens that cycle. The freed slot is visible as in_ready = 1 in the next cycle.
- **Empty:** out_valid = 0. An out_ready assertion is ignored.
- **Flush:** has priority over push and pop in the same cycle.
  - Pointers and count are cleared, and the data in flight that cycle is discarded.
  - in_ready = 1 and out_valid = 0 in the following cycle.
- **Reset (asynchronous, any time, including mid-transfer):**
  - Pointers and count go to 0, out_valid = 0, in_ready = 1.
  - Storage is cleared to 0, so out_state = 0, out_decrypt = 0, out_tag = 0.
- **Protocol:** an upstream stage holding in_valid must keep in_state, in_key, in_decrypt and in_tag stable until the push. The stage itself keeps out_* stable while out_valid && !out_ready.

## Timing
- **Latency:** 1 cycle. A push at edge N presents the result with out_valid = 1 after edge N, when the FIFO was empty.
- **Throughput:**
  - 1 transaction per cycle with DEPTH ≥ 2 and out_ready held high.
  - 1 transaction every 2 cycles with DEPTH = 1.
- **Ordering:** strict FIFO order, regardless of mode mix.
- **Critical path:** the round logic feeding the FIFO write port. There are no combinational paths from input handshake to output handshake.

## Test plan
- **Reset values:** assert reset = 0 mid-burst with count = 2.
  - Required: count = 0, out_valid = 0, in_ready = 1, out_state = 0 immediately, without waiting for a clock edge.
- **FIPS-197 encrypt:** ROUND_NUM = 1, in_state = 193de3bea0f4e22b9ac68d2ae9f84808, in_key = a0fafe1788542cb123a339392a6c7605, in_decrypt = 0, tag = 5.
  - Required: one cycle later out_state = a49c7ff2689f352b6b5bea43026a5049, out_tag = 5.
- **Inverse round trip:** same ROUND_NUM and key, in_state = a49c7ff2689f352b6b5bea43026a5049, in_decrypt = 1.
  - Required: out_state = 193de3bea0f4e22b9ac68d2ae9f84808, out_decrypt = 1.
- **Back-pressure and full:** DEPTH = 2, out_ready = 0, push 3 transactions with tags 1, 2, 3.
  - Required: in_ready drops after 2 pushes, count = 2, tag 3 is held upstream.
  - Then raise out_ready. Required: tags pop in order 1, 2, 3 with no loss or duplication.
- **Simultaneous push and pop:** count = 1, in_valid = out_ready = 1 for 10 cycles with alternating in_decrypt.
  - Required: count stays 1, one output per cycle, each result matches the reference model for its own mode.
- **Flush:** count = 2, and flush, push and pop are all asserted in one cycle.
  - Required: next cycle count = 0 and out_valid = 0. The pushed item never appears.
- **Final round:** ROUND_NUM = `NUM_ROUNDS`.
  - Required: results match the reference model without MixColumns in both modes.
